// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Multi-channel push-button front end. Each channel has a
//            polarity fix-up, a synchroniser, a counter-based debouncer and
//            a hold/repeat state machine that emits one-cycle strobes.
// Ports    : clk         - single clock
//            rst_n       - asynchronous active-low reset
//            button      - raw asynchronous pins, one per channel
//            btn_level   - debounced pressed level (1 = pressed)
//            btn_press   - 1-cycle strobe on accepted press
//            btn_release - 1-cycle strobe on accepted release
//            btn_long    - 1-cycle strobe after LONG_CYCLES of hold
//            btn_repeat  - 1-cycle strobe every REPEAT_CYCLES past long-press
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_BITS       = 2,
    parameter int                  DEBOUNCE_CYCLES = 256,
    parameter int                  LONG_CYCLES     = 12_000_000,
    parameter int                  REPEAT_CYCLES   = 3_000_000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW      = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_long,
    output logic [CHANNELS-1:0] btn_repeat
);

    // Counter widths; one spare bit keeps terminal values representable.
    localparam int c_DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int c_HOLD_W   = $clog2(c_HOLD_MAX) + 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_LONG_LAST = c_HOLD_W'(LONG_CYCLES - 1);
    // Guarded so a disabled repeat (0) does not produce a negative constant.
    localparam logic [c_HOLD_W-1:0] c_REP_LAST  =
        c_HOLD_W'((REPEAT_CYCLES == 0) ? 0 : (REPEAT_CYCLES - 1));

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HELD = 2'd1;
    localparam logic [1:0] c_LONG = 2'd2;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [SYNC_BITS-1:0] r_sync;
        logic                 r_stable;
        logic [c_DB_W-1:0]    r_db_cnt;
        logic [1:0]           r_state;
        logic [c_HOLD_W-1:0]  r_hold_cnt;
        logic                 r_press;
        logic                 r_release;
        logic                 r_long;
        logic                 r_repeat;

        logic                 w_in;
        logic                 w_sync;
        logic                 w_db_done;
        logic                 w_rise;
        logic                 w_fall;
        logic [1:0]           w_state_nxt;
        logic [c_HOLD_W-1:0]  w_hold_cnt_nxt;
        logic                 w_press_nxt;
        logic                 w_release_nxt;
        logic                 w_long_nxt;
        logic                 w_repeat_nxt;

        // Polarity is normalised before the synchroniser.
        assign w_in   = button[i] ^ ACTIVE_LOW[i];
        assign w_sync = r_sync[SYNC_BITS-1];

        // The debouncer's acceptance edge doubles as the FSM's rise/fall
        // event, so press/release strobes land on the same edge as the level.
        assign w_db_done = (w_sync != r_stable) && (r_db_cnt == c_DB_LAST);
        assign w_rise    = w_db_done && !r_stable;
        assign w_fall    = w_db_done &&  r_stable;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync   <= '0;
                r_stable <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_BITS-2:0], w_in};
                if (w_sync == r_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_stable <= ~r_stable;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= c_IDLE;
                r_hold_cnt <= '0;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_long     <= 1'b0;
                r_repeat   <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_hold_cnt <= w_hold_cnt_nxt;
                r_press    <= w_press_nxt;
                r_release  <= w_release_nxt;
                r_long     <= w_long_nxt;
                r_repeat   <= w_repeat_nxt;
            end
        end

        // Release is tested first in every held state so it pre-empts a
        // long/repeat strobe due on the same edge.
        always_comb begin
            w_state_nxt    = r_state;
            w_hold_cnt_nxt = r_hold_cnt;
            w_press_nxt    = 1'b0;
            w_release_nxt  = 1'b0;
            w_long_nxt     = 1'b0;
            w_repeat_nxt   = 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_rise) begin
                        w_press_nxt    = 1'b1;
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = c_HELD;
                    end
                end
                c_HELD: begin
                    if (w_fall) begin
                        w_release_nxt  = 1'b1;
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = c_IDLE;
                    end else if (r_hold_cnt == c_LONG_LAST) begin
                        w_long_nxt     = 1'b1;
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = c_LONG;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                c_LONG: begin
                    if (w_fall) begin
                        w_release_nxt  = 1'b1;
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = c_IDLE;
                    end else if (REPEAT_CYCLES != 0) begin
                        if (r_hold_cnt == c_REP_LAST) begin
                            w_repeat_nxt   = 1'b1;
                            w_hold_cnt_nxt = '0;
                        end else begin
                            w_hold_cnt_nxt = r_hold_cnt + c_HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle state.
                    w_state_nxt    = c_IDLE;
                    w_hold_cnt_nxt = '0;
                end
            endcase
        end

        assign btn_level[i]   = r_stable;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
        assign btn_long[i]    = r_long;
        assign btn_repeat[i]  = r_repeat;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner. DUT A uses the
//            repeat-enabled configuration, DUT B has repeat disabled.
//            Expected strobe events are queued by the stimulus process and
//            consumed by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int K_REPEAT  = 0;
    localparam int K_LONG    = 1;
    localparam int K_RELEASE = 2;
    localparam int K_PRESS   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] button_a, button_b;
    logic [1:0] level_a, press_a, release_a, long_a, repeat_a;
    logic [1:0] level_b, press_b, release_b, long_b, repeat_b;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    typedef struct {
        int         e;
        logic [7:0] v;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    button_conditioner #(
        .CHANNELS(2), .SYNC_BITS(2), .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(2'b10)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .button(button_a),
        .btn_level(level_a), .btn_press(press_a), .btn_release(release_a),
        .btn_long(long_a), .btn_repeat(repeat_a)
    );

    button_conditioner #(
        .CHANNELS(2), .SYNC_BITS(2), .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(10), .REPEAT_CYCLES(0), .ACTIVE_LOW(2'b10)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .button(button_b),
        .btn_level(level_b), .btn_press(press_b), .btn_release(release_b),
        .btn_long(long_b), .btn_repeat(repeat_b)
    );

    always #5 clk = ~clk;

    // Index of the next rising edge, as seen from a falling edge.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a(input int e, input int kind, input int ch);
        ev_t x;
        x.e = e;
        x.v = 8'(1) << (kind * 2 + ch);
        q_a.push_back(x);
    endtask

    task automatic push_b(input int e, input int kind, input int ch);
        ev_t x;
        x.e = e;
        x.v = 8'(1) << (kind * 2 + ch);
        q_b.push_back(x);
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    // Monitor: compares every observed strobe pattern with the queue head.
    always @(negedge clk) begin
        logic [7:0] vec;
        ev_t        ev;
        int         now;
        now = edge_cnt - 1;

        vec = {press_a, release_a, long_a, repeat_a};
        while (q_a.size() != 0 && q_a[0].e < now) begin
            ev = q_a.pop_front();
            n_tests++; n_fail++;
            $display("FAIL dutA_missed: got none expected %b at edge %0d", ev.v, ev.e);
        end
        if (vec != 8'd0) begin
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL dutA_unexpected: got %b at edge %0d expected none", vec, now);
            end else begin
                ev = q_a.pop_front();
                if (ev.e != now || ev.v != vec) begin
                    n_fail++;
                    $display("FAIL dutA_event: got %b at edge %0d expected %b at edge %0d",
                             vec, now, ev.v, ev.e);
                end
            end
        end

        vec = {press_b, release_b, long_b, repeat_b};
        while (q_b.size() != 0 && q_b[0].e < now) begin
            ev = q_b.pop_front();
            n_tests++; n_fail++;
            $display("FAIL dutB_missed: got none expected %b at edge %0d", ev.v, ev.e);
        end
        if (vec != 8'd0) begin
            n_tests++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL dutB_unexpected: got %b at edge %0d expected none", vec, now);
            end else begin
                ev = q_b.pop_front();
                if (ev.e != now || ev.v != vec) begin
                    n_fail++;
                    $display("FAIL dutB_event: got %b at edge %0d expected %b at edge %0d",
                             vec, now, ev.v, ev.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, s, r;
        rst_n    = 1'b0;
        button_a = 2'b10;
        button_b = 2'b10;

        // Reset state
        @(negedge clk); #1;
        check("reset_outs_a", {22'd0, level_a, press_a, release_a, long_a, repeat_a}, 32'd0);
        check("reset_outs_b", {22'd0, level_b, press_b, release_b, long_b, repeat_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("first_edge_outs_a", {22'd0, level_a, press_a, release_a, long_a, repeat_a}, 32'd0);
        repeat (3) @(negedge clk);

        // Clean press with long and repeats; release lands on a repeat slot
        e0 = edge_cnt;
        button_a[0] = 1'b1;
        push_a(e0 + 5, K_PRESS, 0);
        push_a(e0 + 15, K_LONG, 0);
        for (int k = 18; k <= 42; k += 3) push_a(e0 + k, K_REPEAT, 0);
        push_a(e0 + 45, K_RELEASE, 0);
        wait_edge(e0 + 5); #1;
        check("clean_level_before", {31'd0, level_a[0]}, 32'd0);
        wait_edge(e0 + 6); #1;
        check("clean_level_after", {31'd0, level_a[0]}, 32'd1);
        wait_edge(e0 + 40);
        button_a[0] = 1'b0;
        wait_edge(e0 + 46); #1;
        check("clean_level_released", {31'd0, level_a[0]}, 32'd0);
        wait_edge(e0 + 50);

        // Bounce rejection, then steady press
        @(negedge clk);
        for (int rr = 0; rr < 5; rr++) begin
            for (int k = 0; k < 4; k++) begin
                button_a[0] = (k != 3);
                @(negedge clk);
            end
        end
        s = edge_cnt;
        button_a[0] = 1'b1;
        push_a(s + 5, K_PRESS, 0);
        push_a(s + 11, K_RELEASE, 0);
        wait_edge(s + 6);
        button_a[0] = 1'b0;
        #1 check("bounce_level", {31'd0, level_a[0]}, 32'd1);
        wait_edge(s + 16);

        // Active-low channel 1
        e0 = edge_cnt;
        button_a[1] = 1'b0;
        push_a(e0 + 5, K_PRESS, 1);
        push_a(e0 + 13, K_RELEASE, 1);
        wait_edge(e0 + 8);
        button_a[1] = 1'b1;
        #1 check("al_level_pressed", {31'd0, level_a[1]}, 32'd1);
        wait_edge(e0 + 14); #1;
        check("al_level_released", {31'd0, level_a[1]}, 32'd0);
        wait_edge(e0 + 20);

        // Release falls on the edge the long strobe would fire
        e0 = edge_cnt;
        button_a[0] = 1'b1;
        push_a(e0 + 5, K_PRESS, 0);
        push_a(e0 + 15, K_RELEASE, 0);
        wait_edge(e0 + 10);
        button_a[0] = 1'b0;
        wait_edge(e0 + 16); #1;
        check("collision_level", {31'd0, level_a[0]}, 32'd0);
        wait_edge(e0 + 20);
        e1 = edge_cnt;
        button_a[0] = 1'b1;
        push_a(e1 + 5, K_PRESS, 0);
        push_a(e1 + 11, K_RELEASE, 0);
        wait_edge(e1 + 6);
        button_a[0] = 1'b0;
        wait_edge(e1 + 16);

        // Reset mid-hold in LONG
        e0 = edge_cnt;
        button_a[0] = 1'b1;
        push_a(e0 + 5, K_PRESS, 0);
        push_a(e0 + 15, K_LONG, 0);
        push_a(e0 + 18, K_REPEAT, 0);
        wait_edge(e0 + 20);
        #1 check("pre_reset_level", {31'd0, level_a[0]}, 32'd1);
        rst_n = 1'b0;
        #1 check("async_reset_outs_a", {22'd0, level_a, press_a, release_a, long_a, repeat_a}, 32'd0);
        @(negedge clk); #1;
        check("in_reset_outs_a", {22'd0, level_a, press_a, release_a, long_a, repeat_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r = edge_cnt;
        push_a(r + 5, K_PRESS, 0);
        push_a(r + 11, K_RELEASE, 0);
        wait_edge(r + 6);
        button_a[0] = 1'b0;
        wait_edge(r + 16);

        // Repeat disabled (DUT B)
        e0 = edge_cnt;
        button_b[0] = 1'b1;
        push_b(e0 + 5, K_PRESS, 0);
        push_b(e0 + 15, K_LONG, 0);
        push_b(e0 + 45, K_RELEASE, 0);
        wait_edge(e0 + 20); #1;
        check("norep_level", {31'd0, level_b[0]}, 32'd1);
        wait_edge(e0 + 40);
        button_b[0] = 1'b0;
        wait_edge(e0 + 52);

        check("queue_a_drained", q_a.size(), 32'd0);
        check("queue_b_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
